tr_fifo: RTL and testbench
==========================

TR_FIFO -- requirements
Module: tr_fifo

Interface
REQ-001 Parameter WIDTH, default 8, data width in bits; legal range 8..32.
REQ-002 Parameter DEPTH, default 4, number of entries; SHALL be a power of two, 2..16.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-005 din  input  WIDTH  write data, taken from the bus low bits.
REQ-006 trload  input  1  push request; writes din when accepted.
REQ-007 trread  input  1  pop request; retires the head entry when accepted.
REQ-008 clr  input  1  synchronous flush from the controller.
REQ-009 dout  output  WIDTH  head entry, first-word-fall-through; drives the bus low bits.
REQ-010 empty  output  1  high when count equals 0.
REQ-011 full  output  1  high when count equals DEPTH.
REQ-012 count  output  log2(DEPTH)+1  number of valid entries.
REQ-013 ovf  output  1  sticky flag: push refused while full.
REQ-014 udf  output  1  sticky flag: pop refused while empty.

Function
REQ-015 Push is accepted when trload=1 and (full=0, or trread=1 with the pop accepted in the same cycle).
REQ-016 An accepted push writes din at the write pointer, and the write pointer advances modulo DEPTH.
REQ-017 Pop is accepted when trread=1 and empty=0, and the read pointer advances modulo DEPTH.
REQ-018 Pointer wrap-around SHALL be seamless; no entry is lost or duplicated across the DEPTH-1 to 0 boundary.
REQ-019 count: +1 on push only, -1 on pop only, unchanged on simultaneous push and pop or on neither.
REQ-020 Simultaneous push and pop when empty: pop is refused (udf sets), push is accepted, and count becomes 1.
REQ-021 Simultaneous push and pop when full: both are accepted, count stays DEPTH, and ovf is not set.
REQ-022 Push refused while full (no pop in that cycle): the storage is unchanged and ovf=1 from the next cycle.
REQ-023 Pop refused while empty: no state change except udf=1 from the next cycle.
REQ-024 dout SHALL equal the entry at the read pointer when empty=0, and all-zero when empty=1.
REQ-025 dout is combinational from the registered pointers and storage only, never directly from din.
REQ-026 Write-to-read latency: a word pushed into an empty buffer appears on dout in the cycle after the push edge.
REQ-027 clr=1: pointers and count return to 0, ovf and udf clear, and any push or pop in the same cycle is ignored.
REQ-028 ovf and udf stay set until rst or clr.
REQ-029 The storage array need not be cleared by clr, but it is never visible on dout while empty=1.

Reset
REQ-030 rst=1 at a rising edge: pointers 0, count 0, empty 1, full 0, ovf 0, udf 0, dout 0.
REQ-031 rst has priority over clr, trload and trread; reset mid-operation discards all entries.
REQ-032 Storage contents are zeroed on rst so that post-reset simulation carries no X values.

Structure
REQ-033 A single module with no sub-module; storage is a register array of DEPTH x WIDTH.
REQ-034 The pointer width constant and the DEPTH legality check (power of two, 2..16) live in the shared CPU package.
REQ-035 WIDTH=8, DEPTH=1 behaviour is not supported; use the plain temporary register for that case.

Verification
REQ-036 Scenario: rst; push 0x11, 0x22, 0x33 -> dout=0x11 with count=3; pop -> dout=0x22 with count=2.
REQ-037 Scenario: DEPTH=4; push 0xA0..0xA3 -> full=1; push 0xFF -> ovf=1, and popping 4 times yields A0, A1, A2, A3 in order.
REQ-038 Scenario: while full, push 0x55 and pop together -> count=4, ovf=0, and 0x55 emerges after three further pops.
REQ-039 Scenario: on empty, pop alone -> udf=1, dout=0; then push and pop together -> count=1, dout=din.
REQ-040 Scenario: 10 push/pop pairs across wrap -> data is preserved in order and count never exceeds DEPTH.
REQ-041 Scenario: with count=3, assert clr together with trload -> empty=1, count=0, dout=0, and ovf and udf cleared; rst mid-stream gives the same result.

Source files
------------

// File: rtl/tr_fifo_pkg.sv
// Shared constants and elaboration-time helpers for the temporary-register FIFO.
// Holds the pointer width calculation and the DEPTH legality rule.
package tr_fifo_pkg;

  // Width of a read/write pointer for a buffer of the given depth.
  function automatic int ptr_width(input int depth);
    return $clog2(depth);
  endfunction

  // DEPTH must be a power of two between 2 and 16 inclusive.
  function automatic bit depth_legal(input int depth);
    return (depth >= 32'sd2) && (depth <= 32'sd16) &&
           ((depth & (depth - 32'sd1)) == 32'sd0);
  endfunction

  // WIDTH must lie between 8 and 32 bits inclusive.
  function automatic bit width_legal(input int width);
    return (width >= 32'sd8) && (width <= 32'sd32);
  endfunction

endpackage

// File: rtl/tr_fifo.sv
// First-word-fall-through FIFO used as the CPU temporary-register buffer,
// with sticky overflow/underflow flags and a synchronous flush.
module tr_fifo
  import tr_fifo_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       trload,
  input  logic                       trread,
  input  logic                       clr,
  output logic [WIDTH-1:0]           dout,
  output logic                       empty,
  output logic                       full,
  output logic [ptr_width(DEPTH):0]  count,
  output logic                       ovf,
  output logic                       udf
);

  localparam int PW = ptr_width(DEPTH);
  localparam logic [PW:0] CNT_FULL = (PW+1)'(DEPTH);
  localparam logic [PW:0] CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE = PW'(1);

  generate
    if (!depth_legal(DEPTH) || !width_legal(WIDTH)) begin : g_bad_params
      $error("tr_fifo: illegal WIDTH/DEPTH parameters");
    end
  endgenerate

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PW-1:0]    wptr_r;
  logic [PW-1:0]    rptr_r;
  logic [PW:0]      count_r;
  logic             ovf_r;
  logic             udf_r;
  logic             empty_s;
  logic             full_s;
  logic             push_ok_s;
  logic             pop_ok_s;

  assign empty_s = (count_r == {(PW+1){1'b0}});
  assign full_s  = (count_r == CNT_FULL);

  // A pop frees a slot for a same-cycle push, so push may proceed while full.
  always_comb begin
    pop_ok_s  = trread && !empty_s;
    push_ok_s = trload && (!full_s || pop_ok_s);
  end

  // Pointer, count, flag and storage update; rst outranks clr outranks traffic.
  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_r[i] <= '0;
      end
    end else if (clr) begin
      wptr_r  <= '0;
      rptr_r  <= '0;
      count_r <= '0;
      ovf_r   <= 1'b0;
      udf_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        mem_r[wptr_r] <= din;
        wptr_r        <= wptr_r + PTR_ONE;
      end
      if (pop_ok_s) begin
        rptr_r <= rptr_r + PTR_ONE;
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CNT_ONE;
        2'b01:   count_r <= count_r - CNT_ONE;
        default: count_r <= count_r;
      endcase
      if (trload && full_s && !pop_ok_s) begin
        ovf_r <= 1'b1;
      end
      if (trread && empty_s) begin
        udf_r <= 1'b1;
      end
    end
  end

  // Head entry falls through; stale storage is masked while empty.
  always_comb begin
    dout = '0;
    if (empty_s) begin
      dout = '0;
    end else begin
      dout = mem_r[rptr_r];
    end
  end

  assign empty = empty_s;
  assign full  = full_s;
  assign count = count_r;
  assign ovf   = ovf_r;
  assign udf   = udf_r;

endmodule

// File: tb/tb_tr_fifo.sv
// Self-checking bench for tr_fifo: directed scenarios plus random traffic
// compared against a queue-based reference model.
module tb_tr_fifo;

  localparam int WIDTH = 8;
  localparam int DEPTH = 4;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [WIDTH-1:0] din = '0;
  logic             trload = 1'b0;
  logic             trread = 1'b0;
  logic             clr = 1'b0;
  logic [WIDTH-1:0] dout;
  logic             empty;
  logic             full;
  logic [2:0]       count;
  logic             ovf;
  logic             udf;

  int errors = 0;
  int checks = 0;

  logic [WIDTH-1:0] q[$];
  bit m_ovf = 1'b0;
  bit m_udf = 1'b0;

  tr_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .din(din), .trload(trload), .trread(trread),
    .clr(clr), .dout(dout), .empty(empty), .full(full), .count(count),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Compare every output against the model's view of the buffer.
  task automatic check_all(input string tag);
    logic [WIDTH-1:0] exp_dout;
    exp_dout = (q.size() > 0) ? q[0] : '0;
    chk({tag, "_dout"},  {24'd0, dout}, {24'd0, exp_dout});
    chk({tag, "_count"}, {29'd0, count}, q.size());
    chk({tag, "_empty"}, {31'd0, empty}, {31'd0, (q.size() == 0)});
    chk({tag, "_full"},  {31'd0, full},  {31'd0, (q.size() == DEPTH)});
    chk({tag, "_ovf"},   {31'd0, ovf},   {31'd0, m_ovf});
    chk({tag, "_udf"},   {31'd0, udf},   {31'd0, m_udf});
  endtask

  // Drive one cycle, advance the model by the FIFO rules, then check outputs.
  task automatic step(input string tag, input logic r, input logic c,
                      input logic ld, input logic rd, input logic [WIDTH-1:0] d);
    bit pop_ok, push_ok;
    rst = r; clr = c; trload = ld; trread = rd; din = d;
    @(posedge clk);
    if (r || c) begin
      q.delete();
      m_ovf = 1'b0;
      m_udf = 1'b0;
    end else begin
      pop_ok  = rd && (q.size() > 0);
      push_ok = ld && ((q.size() < DEPTH) || pop_ok);
      if (rd && q.size() == 0) m_udf = 1'b1;
      if (ld && q.size() == DEPTH && !pop_ok) m_ovf = 1'b1;
      if (pop_ok) void'(q.pop_front());
      if (push_ok) q.push_back(d);
    end
    #1;
    check_all(tag);
  endtask

  initial begin
    // Reset state
    step("rst", 1'b1, 1'b0, 1'b0, 1'b0, 8'h00);
    chk("rst_dout_zero", {24'd0, dout}, 32'h0);
    step("idle", 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);

    // Three pushes then one pop
    step("p11", 1'b0, 1'b0, 1'b1, 1'b0, 8'h11);
    chk("lat_dout", {24'd0, dout}, 32'h11);
    step("p22", 1'b0, 1'b0, 1'b1, 1'b0, 8'h22);
    step("p33", 1'b0, 1'b0, 1'b1, 1'b0, 8'h33);
    chk("s36_count", {29'd0, count}, 32'd3);
    step("pop1", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("s36_dout", {24'd0, dout}, 32'h22);

    // Fill, overflow, drain in order
    step("clr1", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step("fill", 1'b0, 1'b0, 1'b1, 1'b0, 8'hA0 + 8'(i));
    chk("s37_full", {31'd0, full}, 32'd1);
    step("ovf", 1'b0, 1'b0, 1'b1, 1'b0, 8'hFF);
    chk("s37_ovf", {31'd0, ovf}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      chk("s37_order", {24'd0, dout}, 32'hA0 + 32'(i));
      step("drain", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    end

    // Push and pop together while full
    step("clr2", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    for (int i = 0; i < 4; i++) step("fill2", 1'b0, 1'b0, 1'b1, 1'b0, 8'h01 + 8'(i));
    step("pp_full", 1'b0, 1'b0, 1'b1, 1'b1, 8'h55);
    chk("s38_count", {29'd0, count}, 32'd4);
    chk("s38_ovf", {31'd0, ovf}, 32'd0);
    for (int i = 0; i < 3; i++) step("pop3", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("s38_dout", {24'd0, dout}, 32'h55);

    // Underflow, then simultaneous push/pop on empty
    step("clr3", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step("udf", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("s39_udf", {31'd0, udf}, 32'd1);
    step("pp_empty", 1'b0, 1'b0, 1'b1, 1'b1, 8'h77);
    chk("s39_dout", {24'd0, dout}, 32'h77);
    chk("s39_count", {29'd0, count}, 32'd1);

    // Push/pop pairs across pointer wrap
    step("clr4", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step("w0", 1'b0, 1'b0, 1'b1, 1'b0, 8'h30);
    step("w1", 1'b0, 1'b0, 1'b1, 1'b0, 8'h31);
    for (int i = 0; i < 10; i++) step("wrap", 1'b0, 1'b0, 1'b1, 1'b1, 8'h40 + 8'(i));

    // Flush with concurrent push, then reset mid-stream with concurrent push
    step("clr5", 1'b0, 1'b1, 1'b0, 1'b0, 8'h00);
    step("u", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    for (int i = 0; i < 5; i++) step("f3", 1'b0, 1'b0, 1'b1, 1'b0, 8'hC0 + 8'(i));
    step("pp3", 1'b0, 1'b0, 1'b0, 1'b1, 8'h00);
    chk("s41_pre", {29'd0, count}, 32'd3);
    step("clr_ld", 1'b0, 1'b1, 1'b1, 1'b0, 8'hEE);
    chk("s41_clr_empty", {31'd0, empty}, 32'd1);
    for (int i = 0; i < 3; i++) step("g3", 1'b0, 1'b0, 1'b1, 1'b0, 8'hD0 + 8'(i));
    step("rst_ld", 1'b1, 1'b1, 1'b1, 1'b1, 8'hEE);
    chk("s41_rst_count", {29'd0, count}, 32'd0);

    // Random traffic with occasional flush and reset
    for (int i = 0; i < 300; i++) begin
      step("rnd", ($urandom_range(0, 63) == 0), ($urandom_range(0, 31) == 0),
           1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 8'($urandom));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
